// File: rtl/conv_mac_accum_if.sv
// Ready/valid bundle between the window generator, the convolution MAC and the
// output feature-map writer.
interface conv_mac_accum_if #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int OW     = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [KERNEL*KERNEL*N-1:0]   data2conv;
    logic [KERNEL*KERNEL*M-1:0]   w;
    logic [OW-1:0]                bias;
    logic                         out_valid;
    logic                         out_ready;
    logic [OW-1:0]                d_out;
    logic                         out_sat;

    modport master (
        output in_valid, data2conv, w, bias, out_ready,
        input  in_ready, out_valid, d_out, out_sat
    );

    modport slave (
        input  in_valid, data2conv, w, bias, out_ready,
        output in_ready, out_valid, d_out, out_sat
    );
endinterface

// File: rtl/conv_mac_accum.sv
// KxK convolution MAC: per-beat window dot product, CH-beat channel accumulation,
// bias on the first beat, optional ReLU and saturation to OW bits.
module conv_mac_accum #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int E      = 4,
    parameter int CH     = 4,
    parameter int CW     = 2,
    parameter int OW     = 8,
    parameter int SIGNED = 1,
    parameter int RELU   = 0
) (
    input  logic             clk,
    input  logic             rst,
    conv_mac_accum_if.slave  io_bus
);
    localparam int K2 = KERNEL * KERNEL;
    localparam int P  = N + M;
    localparam int S  = P + E;
    localparam int A  = S + CW + 1;

    generate
        if ((1 << E) < K2) begin : g_bad_e
            $error("conv_mac_accum: E too small for KERNEL*KERNEL taps");
        end
        if ((1 << CW) < CH) begin : g_bad_cw
            $error("conv_mac_accum: CW too small for CH");
        end
        if (OW > A) begin : g_bad_ow
            $error("conv_mac_accum: OW exceeds accumulator width");
        end
    endgenerate

    function automatic logic signed [P-1:0] mul(input logic [N-1:0] d, input logic [M-1:0] c);
        logic signed [P-1:0] de;
        logic signed [P-1:0] ce;
        if (SIGNED != 0) begin
            de = P'($signed(d));
            ce = P'($signed(c));
        end else begin
            de = P'($unsigned(d));
            ce = P'($unsigned(c));
        end
        return de * ce;
    endfunction

    function automatic logic signed [S-1:0] ext_ps(input logic signed [P-1:0] x);
        if (SIGNED != 0) return S'(x);
        else             return S'($unsigned(x));
    endfunction

    function automatic logic signed [A-1:0] ext_sa(input logic signed [S-1:0] x);
        if (SIGNED != 0) return A'(x);
        else             return A'($unsigned(x));
    endfunction

    function automatic logic signed [A-1:0] ext_oa(input logic [OW-1:0] x);
        if (SIGNED != 0) return A'($signed(x));
        else             return A'($unsigned(x));
    endfunction

    // ReLU first, then clip to the OW range; the MSB of the result is the clip flag,
    // so a ReLU-zeroed value never reports saturation.
    function automatic logic [OW:0] post(input logic signed [A-1:0] x);
        logic signed [A-1:0] v;
        logic                ovf;
        logic [OW-1:0]       q;
        v   = x;
        ovf = 1'b0;
        if (RELU != 0 && SIGNED != 0 && v[A-1]) v = '0;
        if (SIGNED != 0) begin
            for (int i = OW - 1; i < A; i++) begin
                if (v[i] != v[A-1]) ovf = 1'b1;
            end
            if (!ovf)        q = v[OW-1:0];
            else if (v[A-1]) q = {1'b1, {(OW-1){1'b0}}};
            else             q = {1'b0, {(OW-1){1'b1}}};
        end else begin
            for (int i = OW; i < A; i++) begin
                if (v[i]) ovf = 1'b1;
            end
            q = ovf ? '1 : v[OW-1:0];
        end
        return {ovf, q};
    endfunction

    logic                 w_stall;
    logic                 w_en;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic [CW-1:0]        r_in_cnt;

    logic signed [P-1:0]  w_prod [K2];
    logic                 r_vld_p1;
    logic                 r_first_p1;
    logic                 r_last_p1;
    logic [OW-1:0]        r_bias_p1;
    logic signed [P-1:0]  r_prod_p1 [K2];

    logic signed [S-1:0]  w_sum;
    logic                 r_vld_p2;
    logic                 r_first_p2;
    logic                 r_last_p2;
    logic [OW-1:0]        r_bias_p2;
    logic signed [S-1:0]  r_sum_p2;

    logic signed [A-1:0]  w_acc_next;
    logic [OW:0]          w_post;
    logic signed [A-1:0]  r_acc;
    logic                 r_out_valid;
    logic [OW-1:0]        r_d_out;
    logic                 r_out_sat;

    // A held result freezes the whole pipeline, including the input counter.
    assign w_stall         = r_out_valid && !io_bus.out_ready;
    assign w_en            = !w_stall;
    assign io_bus.in_ready = !rst && !w_stall;
    assign w_accept        = io_bus.in_valid && io_bus.in_ready;
    assign w_first         = (r_in_cnt == '0);
    assign w_last          = (r_in_cnt == CW'(CH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt <= '0;
        end else if (w_accept) begin
            r_in_cnt <= w_last ? '0 : r_in_cnt + CW'(1);
        end
    end

    // Stage 1: per-tap products
    always_comb begin
        for (int i = 0; i < K2; i++) begin
            w_prod[i] = mul(io_bus.data2conv[i*N +: N], io_bus.w[i*M +: M]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_first_p1 <= w_first;
            r_last_p1  <= w_last;
            for (int i = 0; i < K2; i++) begin
                r_prod_p1[i] <= w_prod[i];
            end
            if (w_accept && w_first) r_bias_p1 <= io_bus.bias;
        end
    end

    // Stage 2: window sum
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K2; i++) begin
            w_sum = w_sum + ext_ps(r_prod_p1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
        end else if (w_en) begin
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_first_p2 <= r_first_p1;
            r_last_p2  <= r_last_p1;
            r_bias_p2  <= r_bias_p1;
            r_sum_p2   <= w_sum;
        end
    end

    // Stage 3: channel accumulation and output register
    assign w_acc_next = (r_first_p2 ? ext_oa(r_bias_p2) : r_acc) + ext_sa(r_sum_p2);
    assign w_post     = post(w_acc_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_en && r_vld_p2) begin
                r_acc <= r_last_p2 ? '0 : w_acc_next;
            end
            if (w_en && r_vld_p2 && r_last_p2) begin
                r_out_valid <= 1'b1;
                r_d_out     <= w_post[OW-1:0];
                r_out_sat   <= w_post[OW];
            end else if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.d_out     = r_d_out;
    assign io_bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum: signed, signed+ReLU and unsigned CH=1 instances.
module tb_conv_mac_accum;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv_mac_accum_if #(.KERNEL(3), .N(4), .M(4), .OW(8))  s_if ();
    conv_mac_accum_if #(.KERNEL(3), .N(4), .M(4), .OW(8))  r_if ();
    conv_mac_accum_if #(.KERNEL(3), .N(4), .M(4), .OW(12)) u_if ();

    conv_mac_accum #(.KERNEL(3), .N(4), .M(4), .E(4), .CH(4), .CW(2), .OW(8),
                     .SIGNED(1), .RELU(0)) u_s (.clk(clk), .rst(rst), .io_bus(s_if.slave));
    conv_mac_accum #(.KERNEL(3), .N(4), .M(4), .E(4), .CH(4), .CW(2), .OW(8),
                     .SIGNED(1), .RELU(1)) u_r (.clk(clk), .rst(rst), .io_bus(r_if.slave));
    conv_mac_accum #(.KERNEL(3), .N(4), .M(4), .E(4), .CH(1), .CW(1), .OW(12),
                     .SIGNED(0), .RELU(0)) u_u (.clk(clk), .rst(rst), .io_bus(u_if.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input logic [3:0] d, input logic [3:0] c, input logic [7:0] b);
        s_if.in_valid  = v;
        s_if.data2conv = {9{d}};
        s_if.w         = {9{c}};
        s_if.bias      = b;
    endtask

    task automatic drive_r(input logic v, input logic [3:0] d, input logic [3:0] c, input logic [7:0] b);
        r_if.in_valid  = v;
        r_if.data2conv = {9{d}};
        r_if.w         = {9{c}};
        r_if.bias      = b;
    endtask

    task automatic drive_u(input logic v, input logic [3:0] d, input logic [3:0] c, input logic [11:0] b);
        u_if.in_valid  = v;
        u_if.data2conv = {9{d}};
        u_if.w         = {9{c}};
        u_if.bias      = b;
    endtask

    task automatic wait_out_s(output logic found, output logic [7:0] d, output logic sat);
        found = 1'b0;
        d     = '0;
        sat   = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (s_if.out_valid) begin
                found = 1'b1;
                d     = s_if.d_out;
                sat   = s_if.out_sat;
            end
            tick();
        end
    endtask

    task automatic wait_out_r(output logic found, output logic [7:0] d, output logic sat);
        found = 1'b0;
        d     = '0;
        sat   = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (r_if.out_valid) begin
                found = 1'b1;
                d     = r_if.d_out;
                sat   = r_if.out_sat;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", s_if.out_valid); end
        checks++; if (s_if.d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h want 00", s_if.d_out); end
        checks++; if (s_if.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got %b want 0", s_if.out_sat); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", s_if.in_ready); end
        checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_u got %b want 0", u_if.in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", s_if.in_ready); end
    endtask

    task automatic test_basic();
        for (int b = 0; b < 4; b++) begin
            drive_s(1'b1, 4'd1, 4'd1, 8'd0);
            tick();
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early1 got %b want 0", s_if.out_valid); end
        tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early2 got %b want 0", s_if.out_valid); end
        tick();
        checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", s_if.out_valid); end
        checks++; if (s_if.d_out !== 8'd36) begin errors++; $display("FAIL basic_d_out got %0d want 36", s_if.d_out); end
        checks++; if (s_if.out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", s_if.out_sat); end
        tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", s_if.out_valid); end
    endtask

    task automatic test_bias();
        logic       found;
        logic [7:0] d;
        logic       sat;
        logic [7:0] later [3];
        later[0] = 8'h55;
        later[1] = 8'h7F;
        later[2] = 8'h00;
        for (int b = 0; b < 4; b++) begin
            drive_s(1'b1, 4'd1, 4'd2, 8'hF6);
            tick();
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_s(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bias_timeout got %b want 1", found); end
        checks++; if (d !== 8'd62) begin errors++; $display("FAIL bias_d_out got %0d want 62", d); end
        drive_s(1'b1, 4'd1, 4'd2, 8'hF6);
        tick();
        for (int b = 0; b < 3; b++) begin
            drive_s(1'b1, 4'd1, 4'd2, later[b]);
            tick();
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_s(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL bias2_timeout got %b want 1", found); end
        checks++; if (d !== 8'd62) begin errors++; $display("FAIL bias2_d_out got %0d want 62", d); end
    endtask

    task automatic test_sat();
        logic       found;
        logic [7:0] d;
        logic       sat;
        for (int b = 0; b < 4; b++) begin
            drive_s(1'b1, 4'h8, 4'd7, 8'd0);
            tick();
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_s(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL sat_timeout got %b want 1", found); end
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL sat_d_out got %h want 80", d); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", sat); end
    endtask

    task automatic test_relu();
        logic       found;
        logic [7:0] d;
        logic       sat;
        for (int b = 0; b < 4; b++) begin
            drive_r(1'b1, 4'h8, 4'd7, 8'd0);
            tick();
        end
        drive_r(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_r(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL relu_timeout got %b want 1", found); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL relu_d_out got %h want 00", d); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL relu_sat got %b want 0", sat); end
        for (int b = 0; b < 4; b++) begin
            drive_r(1'b1, 4'd1, 4'd1, 8'd0);
            tick();
        end
        drive_r(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_r(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL relu_pos_timeout got %b want 1", found); end
        checks++; if (d !== 8'd36) begin errors++; $display("FAIL relu_pos_d_out got %0d want 36", d); end
    endtask

    task automatic test_backpressure();
        logic [3:0] bd [8];
        logic [3:0] bw [8];
        logic [7:0] bb [8];
        logic [7:0] got [2];
        int         idx;
        int         stall_left;
        int         ngot;
        logic       stalled;
        logic       acc;
        idx        = 0;
        stall_left = 0;
        ngot       = 0;
        stalled    = 1'b0;
        got[0]     = '0;
        got[1]     = '0;
        for (int i = 0; i < 8; i++) begin
            bd[i] = 4'd1;
            bw[i] = (i < 4) ? 4'd1 : 4'd2;
            bb[i] = (i < 4) ? 8'd0 : 8'hF6;
        end
        for (int c = 0; c < 40 && ngot < 2; c++) begin
            if (s_if.out_valid && !stalled) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            s_if.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (idx < 8) drive_s(1'b1, bd[idx], bw[idx], bb[idx]);
            else         drive_s(1'b0, 4'd0, 4'd0, 8'd0);
            #1;
            if (s_if.out_valid && !s_if.out_ready) begin
                checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, s_if.in_ready); end
                checks++; if (s_if.d_out !== 8'd36) begin errors++; $display("FAIL bp_hold cycle %0d got %0d want 36", c, s_if.d_out); end
            end
            if (s_if.out_valid && s_if.out_ready) begin
                got[ngot] = s_if.d_out;
                ngot++;
            end
            acc = s_if.in_valid && s_if.in_ready;
            tick();
            if (acc) idx++;
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        s_if.out_ready = 1'b1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL bp_first_out got %b want 1", stalled); end
        checks++; if (ngot != 2) begin errors++; $display("FAIL bp_count got %0d want 2", ngot); end
        checks++; if (got[0] !== 8'd36) begin errors++; $display("FAIL bp_first got %0d want 36", got[0]); end
        checks++; if (got[1] !== 8'd62) begin errors++; $display("FAIL bp_second got %0d want 62", got[1]); end
        checks++; if (idx != 8) begin errors++; $display("FAIL bp_beats got %0d want 8", idx); end
    endtask

    task automatic test_reset_mid();
        logic       found;
        logic [7:0] d;
        logic       sat;
        drive_s(1'b1, 4'd3, 4'd3, 8'd0);
        tick();
        tick();
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        rst = 1'b1;
        tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", s_if.out_valid); end
        checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", s_if.in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b want 0", s_if.out_valid); end
        for (int b = 0; b < 4; b++) begin
            drive_s(1'b1, 4'd1, 4'd1, 8'd0);
            tick();
            checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_group beat %0d got %b want 0", b, s_if.out_valid); end
        end
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        wait_out_s(found, d, sat);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_timeout got %b want 1", found); end
        checks++; if (d !== 8'd36) begin errors++; $display("FAIL rstmid_d_out got %0d want 36", d); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) drive_u(1'b1, 4'd15, 4'd15, 12'd0);
            else       drive_u(1'b0, 4'd0, 4'd0, 12'd0);
            exp_v = (c >= 3) && (c <= 7);
            checks++; if (u_if.out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cycle %0d got %b want %b", c, u_if.out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (u_if.d_out !== 12'd2025) begin errors++; $display("FAIL b2b_d_out cycle %0d got %0d want 2025", c, u_if.d_out); end
                checks++; if (u_if.out_sat !== 1'b0) begin errors++; $display("FAIL b2b_sat cycle %0d got %b want 0", c, u_if.out_sat); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_s(1'b0, 4'd0, 4'd0, 8'd0);
        drive_r(1'b0, 4'd0, 4'd0, 8'd0);
        drive_u(1'b0, 4'd0, 4'd0, 12'd0);
        s_if.out_ready = 1'b1;
        r_if.out_ready = 1'b1;
        u_if.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_bias();
        test_sat();
        test_relu();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
